// File: rtl/mem_stage_pkg.sv
// Shared types for the memory access stage.
//   exc_cause_t : exception cause reported alongside valid_M/exc_M
//   mem_state_t : control state of the stage (IDLE, ACCESS, DONE)
package mem_stage_pkg;

    localparam int unsigned XLEN            = 64;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_BUS_ERR  = 2'd2,
        EXC_TIMEOUT  = 2'd3
    } exc_cause_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // A doubleword access must sit on an 8-byte boundary.
    function automatic logic dword_misaligned(input logic [2:0] low_bits);
        return low_bits != 3'b000;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts request cycles without dmem_ready and flags the last allowed one.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   clr         : return the count to zero
//   en          : advance the count by one
//   expired     : count has reached TIMEOUT-1
module mem_timeout_counter
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    // Wait-cycle counter, cleared whenever no access is pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: one doubleword load/store per instruction over a req/ready
// handshake, branch resolution and memory exception reporting.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   valid_in, MemRead, MemWrite,
//   Branch, zero_E, aluResult_E,
//   writeData_E, PCBranch_E         : instruction from execute
//   dmem_req/we/addr/wdata          : request to data memory
//   dmem_ready/rdata/err            : response from data memory
//   stall_M                         : upstream must hold its outputs
//   valid_M, readData_M, aluResult_M,
//   PCBranch_M, PCSrc_M, exc_M,
//   exc_cause_M                     : results, qualified by valid_M
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned memory ops
// with EXC_MISALIGN instead of sending them to memory.
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned N       = XLEN,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         Branch,
    input  logic         zero_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [N-1:0] dmem_wdata,
    input  logic         dmem_ready,
    input  logic [N-1:0] dmem_rdata,
    input  logic         dmem_err,
    output logic         stall_M,
    output logic         valid_M,
    output logic [N-1:0] readData_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,
    output logic         exc_M,
    output exc_cause_t   exc_cause_M
);

    mem_state_t   state;
    logic         we_q;
    logic         pcsrc_q;
    logic [N-1:0] addr_q;
    logic [N-1:0] wdata_q;

    logic mem_op;
    logic misaligned;
    logic accept_mem;
    logic expired;

    assign mem_op = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & dword_misaligned(aluResult_E[2:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign accept_mem = (state == IDLE) & valid_in & mem_op & ~misaligned;

    // Stall covers the accepting cycle and every request cycle; DONE releases upstream.
    assign stall_M = accept_mem | (state == ACCESS);

    // Request lines come straight from state and latches so reset drops them at once.
    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = (state == ACCESS) & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != ACCESS),
        .en      ((state == ACCESS) & ~dmem_ready),
        .expired (expired)
    );

    // Control state, request latches and registered results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            pcsrc_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            valid_M     <= 1'b0;
            readData_M  <= '0;
            aluResult_M <= '0;
            PCBranch_M  <= '0;
            PCSrc_M     <= 1'b0;
            exc_M       <= 1'b0;
            exc_cause_M <= EXC_NONE;
        end else begin
            valid_M     <= 1'b0;
            exc_M       <= 1'b0;
            exc_cause_M <= EXC_NONE;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        aluResult_M <= aluResult_E;
                        PCBranch_M  <= PCBranch_E;
                        readData_M  <= '0;
                        if (!mem_op) begin
                            valid_M <= 1'b1;
                            PCSrc_M <= Branch & zero_E;
                        end else if (misaligned) begin
                            valid_M     <= 1'b1;
                            exc_M       <= 1'b1;
                            exc_cause_M <= EXC_MISALIGN;
                            PCSrc_M     <= 1'b0;
                        end else begin
                            // Load wins when both MemRead and MemWrite are set.
                            we_q    <= MemWrite & ~MemRead;
                            addr_q  <= aluResult_E;
                            wdata_q <= writeData_E;
                            pcsrc_q <= Branch & zero_E;
                            state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ready takes priority over a timeout in the same cycle.
                    if (dmem_ready) begin
                        readData_M  <= we_q ? '0 : dmem_rdata;
                        exc_M       <= dmem_err;
                        exc_cause_M <= dmem_err ? EXC_BUS_ERR : EXC_NONE;
                        PCSrc_M     <= pcsrc_q & ~dmem_err;
                        valid_M     <= 1'b1;
                        state       <= DONE;
                    end else if (expired) begin
                        readData_M  <= '0;
                        exc_M       <= 1'b1;
                        exc_cause_M <= EXC_TIMEOUT;
                        PCSrc_M     <= 1'b0;
                        valid_M     <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: upstream driver issues directed
// then random instructions, a memory responder follows a per-request plan, and
// a monitor compares every valid_M against a queued reference result.
module tb_memory_access_stage;

    localparam int unsigned TIMEOUT = 16;
    localparam int          WD_LIMIT = 4 * TIMEOUT + 20;
    localparam int          N_RAND  = 300;

    typedef struct {
        logic        rd, wr, br, z;
        logic [63:0] alu, wd, pcb;
        int          w;
        logic        err;
        logic [63:0] rdata;
    } instr_t;

    typedef struct {
        logic [63:0] alu, pcb, rdata;
        logic        pcsrc, exc;
        logic [1:0]  cause;
    } exp_t;

    typedef struct {
        logic [63:0] addr, wdata;
        logic        we;
        int          w;
        logic        err;
        logic [63:0] rdata;
    } plan_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, Branch = 1'b0, zero_E = 1'b0;
    logic [63:0] aluResult_E = '0, writeData_E = '0, PCBranch_E = '0;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        dmem_err = 1'b0;
    logic        stall_M, valid_M, PCSrc_M, exc_M;
    logic [63:0] readData_M, aluResult_M, PCBranch_M;
    logic [1:0]  exc_cause_M;

    exp_t  exp_q[$];
    plan_t plan_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.N(64), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Branch      (Branch),
        .zero_E      (zero_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .PCBranch_E  (PCBranch_E),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .dmem_err    (dmem_err),
        .stall_M     (stall_M),
        .valid_M     (valid_M),
        .readData_M  (readData_M),
        .aluResult_M (aluResult_M),
        .PCBranch_M  (PCBranch_M),
        .PCSrc_M     (PCSrc_M),
        .exc_M       (exc_M),
        .exc_cause_M (exc_cause_M)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic is_mis(input instr_t t);
`ifdef MEM_ALIGN_CHECK_EN
        return (t.rd | t.wr) && (t.alu[2:0] != 3'b000);
`else
        return 1'b0;
`endif
    endfunction

    // Reference result of one instruction given the memory's planned behaviour.
    function automatic exp_t model(input instr_t t);
        exp_t e;
        e.alu   = t.alu;
        e.pcb   = t.pcb;
        e.rdata = 64'd0;
        e.exc   = 1'b0;
        e.cause = 2'd0;
        e.pcsrc = t.br & t.z;
        if (t.rd | t.wr) begin
            if (is_mis(t)) begin
                e.exc = 1'b1; e.cause = 2'd1; e.pcsrc = 1'b0;
            end else if (t.w >= int'(TIMEOUT)) begin
                e.exc = 1'b1; e.cause = 2'd3; e.pcsrc = 1'b0;
            end else begin
                if (t.rd) e.rdata = t.rdata;
                if (t.err) begin
                    e.exc = 1'b1; e.cause = 2'd2; e.pcsrc = 1'b0;
                end
            end
        end
        return e;
    endfunction

    function automatic instr_t gen(input int i);
        instr_t t;
        int k;
        t.rd = 1'b0; t.wr = 1'b0;
        t.br = 1'($urandom_range(0, 1));
        t.z  = 1'($urandom_range(0, 1));
        t.alu   = {$urandom, $urandom};
        t.alu[2:0] = 3'b000;
        t.wd    = {$urandom, $urandom};
        t.pcb   = {$urandom, $urandom};
        t.rdata = {$urandom, $urandom};
        t.err   = ($urandom_range(0, 4) == 0);
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3, 4, 5, 6: t.w = $urandom_range(0, 3);
            7:                   t.w = TIMEOUT - 1;
            8:                   t.w = TIMEOUT;
            default:             t.w = $urandom_range(4, 10);
        endcase
        k = $urandom_range(0, 9);
        if (k >= 4 && k <= 6) t.rd = 1'b1;
        else if (k == 7 || k == 8) t.wr = 1'b1;
        else if (k == 9) begin t.rd = 1'b1; t.wr = 1'b1; end
        if ($urandom_range(0, 3) == 0) t.alu[2:0] = 3'($urandom_range(1, 7));
        case (i)
            0: begin t.rd = 0; t.wr = 0; t.br = 0; t.alu = 64'h10; end
            1: begin t.rd = 1; t.wr = 0; t.br = 0; t.alu = 64'h40; t.w = 2; t.err = 0; t.rdata = 64'hDEADBEEF; end
            2: begin t.rd = 0; t.wr = 1; t.br = 0; t.alu = 64'h08; t.wd = 64'h1234; t.w = 0; t.err = 0; end
            3: begin t.rd = 1; t.wr = 0; t.br = 0; t.alu = 64'h100; t.w = TIMEOUT; end
            4: begin t.rd = 1; t.wr = 0; t.br = 0; t.alu = 64'h80; t.w = 0; t.err = 1; end
            5: begin t.rd = 0; t.wr = 0; t.br = 1; t.z = 1; t.pcb = 64'h1000; end
            6: begin t.rd = 1; t.wr = 0; t.br = 0; t.alu = 64'h44; t.w = 0; t.err = 0; end
            7: begin t.rd = 1; t.wr = 0; t.br = 0; t.alu = 64'h48; t.w = TIMEOUT - 1; t.err = 0; end
            default: ;
        endcase
        return t;
    endfunction

    // Present one instruction and hold it until upstream may advance.
    task automatic issue(input instr_t t, input logic expect_result);
        plan_t p;
        logic  s;
        int    n;
        @(negedge clk);
        if ($urandom_range(0, 4) == 0) begin
            valid_in = 1'b0;
            @(negedge clk);
        end
        valid_in    = 1'b1;
        MemRead     = t.rd;
        MemWrite    = t.wr;
        Branch      = t.br;
        zero_E      = t.z;
        aluResult_E = t.alu;
        writeData_E = t.wd;
        PCBranch_E  = t.pcb;
        if (expect_result) exp_q.push_back(model(t));
        if ((t.rd | t.wr) && !is_mis(t)) begin
            p.addr  = t.alu;
            p.wdata = t.wd;
            p.we    = t.wr & ~t.rd;
            p.w     = t.w;
            p.err   = t.err;
            p.rdata = t.rdata;
            plan_q.push_back(p);
        end
        n = 0;
        forever begin
            #4;
            s = stall_M;
            @(posedge clk);
            if (!s) break;
            n++;
            if (n > 200) begin
                $display("FAIL stall_stuck: got stall for %0d cycles expected release", n);
                $fatal(1, "stall never released");
            end
            @(negedge clk);
        end
    endtask

    // Memory responder and scoreboard monitor, both sampling on the falling edge.
    plan_t cur;
    exp_t  e;
    logic  mem_active = 1'b0;
    int    req_cnt = 0;
    int    wd = 0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_ctrl", 64'({dmem_req, dmem_we, valid_M, stall_M, exc_M, PCSrc_M, exc_cause_M}), 64'd0);
            chk("reset_data", aluResult_M | readData_M | PCBranch_M | dmem_addr | dmem_wdata, 64'd0);
            exp_q.delete();
            plan_q.delete();
            mem_active = 1'b0;
            dmem_ready = 1'b0;
            dmem_err   = 1'b0;
            wd = 0;
        end else begin
            if (dmem_req) begin
                if (!mem_active) begin
                    if (plan_q.size() == 0) begin
                        chk("unexpected_req", 64'd1, 64'd0);
                        cur.addr = '0; cur.wdata = '0; cur.we = 1'b0;
                        cur.w = 0; cur.err = 1'b0; cur.rdata = '0;
                    end else begin
                        cur = plan_q.pop_front();
                        chk("req_addr", dmem_addr, cur.addr);
                        chk("req_we", 64'(dmem_we), 64'(cur.we));
                        if (cur.we) chk("req_wdata", dmem_wdata, cur.wdata);
                    end
                    mem_active = 1'b1;
                    req_cnt = 0;
                end
                req_cnt++;
                if (cur.w < int'(TIMEOUT) && req_cnt == cur.w + 1) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = cur.rdata;
                    dmem_err   = cur.err;
                end else begin
                    dmem_ready = 1'b0;
                    dmem_rdata = {$urandom, $urandom};
                    dmem_err   = 1'($urandom_range(0, 1));
                end
            end else begin
                if (mem_active) begin
                    chk("req_cycles", 64'(req_cnt),
                        64'((cur.w >= int'(TIMEOUT)) ? int'(TIMEOUT) : cur.w + 1));
                    mem_active = 1'b0;
                end
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = {$urandom, $urandom};
                dmem_err   = 1'($urandom_range(0, 1));
            end

            if (valid_M) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("aluResult_M", aluResult_M, e.alu);
                    chk("PCBranch_M", PCBranch_M, e.pcb);
                    chk("readData_M", readData_M, e.rdata);
                    chk("PCSrc_M", 64'(PCSrc_M), 64'(e.pcsrc));
                    chk("exc_M", 64'(exc_M), 64'(e.exc));
                    chk("exc_cause_M", 64'(exc_cause_M), 64'(e.cause));
                end
                wd = 0;
            end else if (exp_q.size() != 0) begin
                wd++;
                if (wd > WD_LIMIT) begin
                    chk("valid_timeout", 64'(wd), 64'(WD_LIMIT));
                    void'(exp_q.pop_front());
                    wd = 0;
                end
            end
        end
    end

    initial begin
        instr_t t;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < N_RAND; i++) begin
            t = gen(i);
            issue(t, 1'b1);
        end
        @(negedge clk);
        valid_in = 1'b0;
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);

        // Reset in the middle of an outstanding load.
        valid_in    = 1'b1;
        MemRead     = 1'b1;
        MemWrite    = 1'b0;
        Branch      = 1'b0;
        aluResult_E = 64'h200;
        begin
            plan_t p;
            p.addr = 64'h200; p.wdata = '0; p.we = 1'b0;
            p.w = 10 * TIMEOUT; p.err = 1'b0; p.rdata = '0;
            plan_q.push_back(p);
        end
        repeat (4) @(posedge clk);
        #1;
        reset    = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        t = gen(0);
        t.alu = 64'h5A5A0;
        issue(t, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
